// File: rtl/dmem_port_scheduler_pkg.sv
// Shared definitions for the data-memory port scheduler.
//   - optype encodings seen on the load/store request ports
//   - scheduler FSM state encoding
//   - default data-memory latency
//   - load_extract(): narrows raw load data according to the load optype
package dmem_port_scheduler_pkg;

  localparam int unsigned MEM_LATENCY_DEF = 10;

  typedef enum logic [3:0] {
    OP_LB = 4'd7,
    OP_LW = 4'd8,
    OP_SB = 4'd9,
    OP_SW = 4'd10
  } optype_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOOKUP   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } sched_state_e;

  // Byte loads return the low byte zero-extended, whatever supplied the word.
  function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [31:0] raw);
    return (op == OP_LB) ? {24'b0, raw[7:0]} : raw;
  endfunction

endpackage

// File: rtl/dmem_grant_arbiter.sv
// Grant logic between the load queue and the store buffer, plus the
// starvation counter that forces a store through after STARVE_MAX
// consecutive load grants.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   arb_en_i             scheduler is idle and may accept a request
//   ld_valid_i/st_valid_i request valids
//   ld_addr_i/st_addr_i  request word addresses (same-address ordering)
//   grant_ld_o/grant_st_o one-hot grant, only while arb_en_i
module dmem_grant_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_en_i,
  input  logic        ld_valid_i,
  input  logic        st_valid_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] st_addr_i,
  output logic        grant_ld_o,
  output logic        grant_st_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             store_first;

  // A store overtakes a waiting load when the load has been starving it,
  // or when both target the same word (store must be ordered first).
  assign store_first = (starve_cnt_q == CNT_MAX) || (ld_addr_i == st_addr_i);

  always_comb begin
    grant_ld_o = 1'b0;
    grant_st_o = 1'b0;
    if (arb_en_i) begin
      if (ld_valid_i && st_valid_i) begin
        grant_st_o = store_first;
        grant_ld_o = !store_first;
      end else begin
        grant_ld_o = ld_valid_i;
        grant_st_o = st_valid_i;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_st_o || !st_valid_i) begin
      starve_cnt_d = '0;
    end else if (grant_ld_o && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_scheduler.sv
// Schedules loads (cache probe first, data memory on miss) and stores onto
// the single data-memory port. One operation in flight; requesters are
// back-pressured through ld_ready/st_ready, which only rise in IDLE.
// Ports:
//   ld_*      load request (valid/ready, optype, addr, pc, tag)
//   st_*      store request (valid/ready, optype, addr, data, pc)
//   cache_*   probe address out, hit/data in (sampled in LOOKUP)
//   mem_*     data-memory enables and operation fields out; done pulses
//             and read data in
//   resp_*    one-cycle load completion
//   st_done   one-cycle store completion
//   busy, err_timeout  status (err_timeout sticky until reset)
//
// state       | meaning
// ST_IDLE     | arbitrating, ready may be asserted
// ST_LOOKUP   | load probing the cache
// ST_MEM_WAIT | load miss or store on the data-memory port
// ST_RESP     | load response presented for one cycle
module dmem_port_scheduler
  import dmem_port_scheduler_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TAG_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [3:0]       ld_optype,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_pc,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [3:0]       st_optype,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  input  logic             cache_hit,
  input  logic [31:0]      cache_data,
  output logic [31:0]      cache_addr,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic [31:0]      mem_pc,
  output logic [3:0]       mem_optype,
  output logic [TAG_W-1:0] mem_reg,
  output logic             mem_cache_miss,
  input  logic             mem_data_valid,
  input  logic             mem_has_stored,
  input  logic [31:0]      mem_rdata,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic [31:0]      resp_pc,
  output logic             st_done,
  output logic             busy,
  output logic             err_timeout
);

  localparam int unsigned      WD_W    = $clog2(2 * MEM_LATENCY);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(2 * MEM_LATENCY - 1);

  sched_state_e     state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;

  logic             is_st_q;
  logic [3:0]       op_q;
  logic [31:0]      addr_q, data_q, pc_q, rdata_q;
  logic [TAG_W-1:0] tag_q;

  logic             grant_ld, grant_st, arb_en, done_seen;

  assign arb_en    = (state_q == ST_IDLE) && !rst;
  assign done_seen = is_st_q ? mem_has_stored : mem_data_valid;

  dmem_grant_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .arb_en_i   (arb_en),
    .ld_valid_i (ld_valid),
    .st_valid_i (st_valid),
    .ld_addr_i  (ld_addr),
    .st_addr_i  (st_addr),
    .grant_ld_o (grant_ld),
    .grant_st_o (grant_st)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Request latch and response data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_st_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (grant_ld) begin
        is_st_q <= 1'b0;
        op_q    <= ld_optype;
        addr_q  <= ld_addr;
        data_q  <= '0;
        pc_q    <= ld_pc;
        tag_q   <= ld_tag;
      end else if (grant_st) begin
        is_st_q <= 1'b1;
        op_q    <= st_optype;
        addr_q  <= st_addr;
        data_q  <= st_data;
        pc_q    <= st_pc;
        tag_q   <= '0;
      end
      if ((state_q == ST_LOOKUP) && cache_hit) begin
        rdata_q <= load_extract(op_q, cache_data);
      end else if ((state_q == ST_MEM_WAIT) && !is_st_q && mem_data_valid) begin
        rdata_q <= load_extract(op_q, mem_rdata);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_st)      state_d = ST_MEM_WAIT;
        else if (grant_ld) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: state_d = cache_hit ? ST_RESP : ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (done_seen) begin
          state_d = is_st_q ? ST_IDLE : ST_RESP;
        end else if (wd_q == WD_LAST) begin
          // Memory never answered: abandon the operation silently.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready       = grant_ld;
    st_ready       = grant_st;
    busy           = (state_q != ST_IDLE);
    err_timeout    = err_q;
    cache_addr     = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_data       = '0;
    mem_pc         = '0;
    mem_optype     = '0;
    mem_reg        = '0;
    mem_cache_miss = 1'b0;
    resp_valid     = 1'b0;
    resp_tag       = '0;
    resp_data      = '0;
    resp_pc        = '0;
    st_done        = 1'b0;
    unique case (state_q)
      ST_LOOKUP: cache_addr = addr_q;
      ST_MEM_WAIT: begin
        mem_read_en    = !is_st_q;
        mem_write_en   = is_st_q;
        mem_cache_miss = !is_st_q;
        mem_addr       = addr_q;
        mem_data       = data_q;
        mem_pc         = pc_q;
        mem_optype     = op_q;
        mem_reg        = tag_q;
        st_done        = is_st_q && mem_has_stored && !rst;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_tag   = tag_q;
        resp_data  = rdata_q;
        resp_pc    = pc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
module tb_dmem_port_scheduler;
  import dmem_port_scheduler_pkg::*;

  localparam int TAG_W = 6;
  localparam int MEM_LATENCY = 10;

  logic             clk, rst;
  logic             ld_valid, ld_ready, st_valid, st_ready;
  logic [3:0]       ld_optype, st_optype, mem_optype;
  logic [31:0]      ld_addr, ld_pc, st_addr, st_data, st_pc;
  logic [TAG_W-1:0] ld_tag, mem_reg, resp_tag;
  logic             cache_hit;
  logic [31:0]      cache_data, cache_addr;
  logic             mem_read_en, mem_write_en, mem_cache_miss;
  logic [31:0]      mem_addr, mem_data, mem_pc, mem_rdata;
  logic             mem_data_valid, mem_has_stored;
  logic             resp_valid, st_done, busy, err_timeout;
  logic [31:0]      resp_data, resp_pc;

  dmem_port_scheduler #(.MEM_LATENCY(MEM_LATENCY), .STARVE_MAX(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_optype(ld_optype),
    .ld_addr(ld_addr), .ld_pc(ld_pc), .ld_tag(ld_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_optype(st_optype),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .cache_hit(cache_hit), .cache_data(cache_data), .cache_addr(cache_addr),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_pc(mem_pc),
    .mem_optype(mem_optype), .mem_reg(mem_reg), .mem_cache_miss(mem_cache_miss),
    .mem_data_valid(mem_data_valid), .mem_has_stored(mem_has_stored),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_pc(resp_pc), .st_done(st_done), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int st_done_cnt = 0;
  int resp_cnt = 0;
  logic rd_seen = 1'b0;
  logic withhold = 1'b0;
  int mcnt = 0;
  logic [31:0] mem_model [logic [31:0]];

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [31:0]      pc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc++;

  // Data-memory model: done pulse in the MEM_LATENCY-th cycle of an enable.
  always @(posedge clk) begin
    #1;
    mem_data_valid = 1'b0;
    mem_has_stored = 1'b0;
    if (mem_read_en || mem_write_en) begin
      mcnt++;
      if (mcnt == MEM_LATENCY && !withhold) begin
        if (mem_write_en) begin
          mem_has_stored = 1'b1;
          mem_model[mem_addr] = mem_data;
        end else begin
          mem_data_valid = 1'b1;
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end
      end
    end else begin
      mcnt = 0;
    end
  end

  // Response monitor / scoreboard.
  always @(posedge clk) begin
    #3;
    if (mem_read_en) rd_seen = 1'b1;
    if (st_done) st_done_cnt++;
    if (resp_valid) begin
      exp_t e;
      resp_cnt++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL resp_unexpected observed tag=0x%0h expected no response", resp_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_tag", 32'(resp_tag), 32'(e.tag));
        check("resp_data", resp_data, e.data);
        check("resp_pc", resp_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, rd, nld, base, rbase;
    logic got;
    rst = 1'b1;
    ld_valid = 0; st_valid = 0; ld_optype = 0; st_optype = 0;
    ld_addr = 0; ld_pc = 0; ld_tag = 0; st_addr = 0; st_data = 0; st_pc = 0;
    cache_hit = 0; cache_data = 0; mem_rdata = 0;
    mem_data_valid = 0; mem_has_stored = 0;
    mem_model[32'h20] = 32'h123456AB;
    mem_model[32'h30] = 32'h11111111;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ready", {ld_ready, st_ready}, 0);
    check("rst_en", {mem_read_en, mem_write_en}, 0);
    check("rst_resp", {resp_valid, st_done, err_timeout}, 0);
    check("rst_addr", cache_addr | mem_addr | mem_data, 0);
    rst = 1'b0;
    tick();

    // Load hit LW 0x10
    cache_hit = 1; cache_data = 32'hDEADBEEF; rd_seen = 0;
    ld_optype = OP_LW; ld_addr = 32'h10; ld_pc = 32'h100; ld_tag = 6'd5; ld_valid = 1;
    exp_q.push_back('{tag: 6'd5, data: 32'hDEADBEEF, pc: 32'h100});
    #1;
    check("hit_ld_ready", ld_ready, 1);
    check("hit_st_ready", st_ready, 0);
    tick();
    ld_valid = 0; ld_addr = 32'hFFFF_FFFF;
    check("hit_lookup_busy", busy, 1);
    check("hit_cache_addr", cache_addr, 32'h10);
    check("hit_no_resp_yet", resp_valid, 0);
    tick();
    check("hit_resp_t2", resp_valid, 1);
    tick();
    check("hit_idle_t3", busy, 0);
    check("hit_no_mem_read", rd_seen, 0);

    // Load miss LB 0x20
    cache_hit = 0;
    ld_optype = OP_LB; ld_addr = 32'h20; ld_pc = 32'h200; ld_tag = 6'd9; ld_valid = 1;
    exp_q.push_back('{tag: 6'd9, data: 32'h000000AB, pc: 32'h200});
    #1;
    tick();
    ld_valid = 0; ld_addr = 0; t1 = cyc;
    check("miss_cache_addr", cache_addr, 32'h20);
    tick();
    check("miss_rd_en", mem_read_en, 1);
    check("miss_flag", mem_cache_miss, 1);
    check("miss_mem_addr", mem_addr, 32'h20);
    check("miss_mem_reg", 32'(mem_reg), 32'd9);
    check("miss_optype", 32'(mem_optype), 32'd7);
    rd = 0;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      if (mem_read_en) rd++;
      tick();
    end
    check("miss_resp", resp_valid, 1);
    check("miss_resp_cycle", 32'(cyc), 32'(t1 + 11));
    check("miss_rd_cycles", 32'(rd), 32'd10);
    tick();
    check("miss_idle", busy, 0);

    // Store SW 0x4
    st_optype = OP_SW; st_addr = 32'h4; st_data = 32'hCAFEF00D; st_pc = 32'h300; st_valid = 1;
    #1;
    check("st_ready", st_ready, 1);
    check("st_no_ld_ready", ld_ready, 0);
    tick();
    st_valid = 0; st_data = 0; st_addr = 0; t1 = cyc; base = st_done_cnt;
    for (int i = 0; i < 40 && !st_done; i++) begin
      check("st_wr_en_held", mem_write_en, 1);
      check("st_mem_data", mem_data, 32'hCAFEF00D);
      tick();
    end
    check("st_done_pulse", st_done, 1);
    check("st_done_cycle", 32'(cyc), 32'(t1 + 9));
    check("st_mem_addr", mem_addr, 32'h4);
    tick();
    check("st_idle_after", {busy, mem_write_en}, 0);
    tick();
    check("st_done_once", 32'(st_done_cnt), 32'(base + 1));

    // Starvation: loads and stores valid continuously, distinct addresses
    cache_hit = 1; cache_data = 32'h0BADF00D;
    ld_optype = OP_LW; ld_addr = 32'h100; ld_pc = 32'h400; ld_tag = 6'd12; ld_valid = 1;
    st_optype = OP_SW; st_addr = 32'h200; st_data = 32'h77; st_pc = 32'h500; st_valid = 1;
    nld = 0; got = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      check("one_grant", ld_ready & st_ready, 0);
      if (ld_ready) begin
        nld++;
        exp_q.push_back('{tag: 6'd12, data: 32'h0BADF00D, pc: 32'h400});
      end
      if (st_ready) begin
        got = 1;
        check("starve_at_max", 32'(dut.u_arb.starve_cnt_q), 32'd4);
      end
      tick();
      if (got) break;
    end
    check("starve_cnt_clear", 32'(dut.u_arb.starve_cnt_q), 0);
    ld_valid = 0; st_valid = 0;
    check("starve_store_granted", got, 1);
    check("starve_loads_before", 32'(nld), 32'd4);
    for (int i = 0; i < 40 && busy; i++) tick();
    check("starve_idle", busy, 0);

    // Same address 0x30: store must go first
    cache_hit = 0;
    ld_optype = OP_LW; ld_addr = 32'h30; ld_pc = 32'h600; ld_tag = 6'd3; ld_valid = 1;
    st_optype = OP_SW; st_addr = 32'h30; st_data = 32'h5A5A5A5A; st_pc = 32'h700; st_valid = 1;
    #1;
    check("raw_st_first", st_ready, 1);
    check("raw_ld_held", ld_ready, 0);
    tick();
    st_valid = 0;
    exp_q.push_back('{tag: 6'd3, data: 32'h5A5A5A5A, pc: 32'h600});
    got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ld_ready) got = 1;
      tick();
      if (got) break;
    end
    ld_valid = 0;
    check("raw_ld_accepted", got, 1);
    for (int i = 0; i < 40 && !resp_valid; i++) tick();
    check("raw_resp", resp_valid, 1);
    tick();

    // Watchdog timeout
    withhold = 1; cache_hit = 0;
    ld_optype = OP_LW; ld_addr = 32'h40; ld_pc = 32'h800; ld_tag = 6'd7; ld_valid = 1;
    #1;
    tick();
    ld_valid = 0; rbase = resp_cnt; rd = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      if (mem_read_en) begin
        rd++;
        if (rd == 20) check("wd_err_not_early", err_timeout, 0);
      end
      tick();
    end
    check("wd_rd_cycles", 32'(rd), 32'd20);
    check("wd_err_set", err_timeout, 1);
    check("wd_idle", {busy, mem_read_en}, 0);
    tick(); tick();
    check("wd_err_sticky", err_timeout, 1);
    check("wd_no_resp", 32'(resp_cnt), 32'(rbase));

    // Reset during a store in MEM_WAIT
    st_optype = OP_SW; st_addr = 32'h50; st_data = 32'h99; st_pc = 32'h900; st_valid = 1;
    #1;
    tick();
    st_valid = 0;
    tick(); tick(); tick(); tick();
    check("rst_mid_wr_en", mem_write_en, 1);
    base = st_done_cnt; rbase = resp_cnt;
    rst = 1;
    tick();
    check("rstm_busy", busy, 0);
    check("rstm_en", {mem_read_en, mem_write_en, mem_cache_miss}, 0);
    check("rstm_fields", mem_addr | mem_data | mem_pc | cache_addr, 0);
    check("rstm_flags", {resp_valid, st_done, err_timeout, ld_ready, st_ready}, 0);
    rst = 0; withhold = 0;
    tick(); tick();
    check("rstm_no_st_done", 32'(st_done_cnt), 32'(base));
    check("rstm_no_resp", 32'(resp_cnt), 32'(rbase));

    // Recovery load hit
    cache_hit = 1; cache_data = 32'h600DCAFE;
    ld_optype = OP_LW; ld_addr = 32'h60; ld_pc = 32'hA00; ld_tag = 6'd1; ld_valid = 1;
    exp_q.push_back('{tag: 6'd1, data: 32'h600DCAFE, pc: 32'hA00});
    #1;
    tick();
    ld_valid = 0;
    for (int i = 0; i < 10 && !resp_valid; i++) tick();
    check("rec_resp", resp_valid, 1);
    tick(); tick();
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_port_scheduler.md
# dmem_port_scheduler

Arbitrates the load queue and the store buffer onto the single read/write port of the data memory, which has a fixed multi-cycle latency. Sits between the load/store unit and the cache/data-memory pair. Each load probes the cache first and goes to the data memory only on a miss; stores always go to the data memory. Only one memory operation is in flight at a time; every other requester stalls through ready/valid back-pressure.

## Interface
Parameters:
- MEM_LATENCY, 10: data-memory cycles from port enable to done pulse
- STARVE_MAX, 4: consecutive load grants allowed while a store waits
- TAG_W, 6: destination physical-register tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid / ld_ready  in / out  1  load request handshake
- ld_optype  in  4  LB=7, LW=8
- ld_addr, ld_pc  in  32  load word address and PC
- ld_tag  in  TAG_W  destination register
- st_valid / st_ready  in / out  1  store request handshake
- st_optype  in  4  SB=9, SW=10
- st_addr, st_data, st_pc  in  32  store word address, data and PC
- cache_hit  in  1  probe result for cache_addr, valid in LOOKUP
- cache_data  in  32  hit data
- cache_addr  out  32  probe address
- mem_read_en, mem_write_en  out  1  data-memory enables
- mem_addr, mem_data, mem_pc  out  32  operation fields
- mem_optype  out  4  operation type
- mem_reg  out  TAG_W  load destination tag
- mem_cache_miss  out  1  set for loads sent to the data memory
- mem_data_valid, mem_has_stored  in  1  data-memory done pulses
- mem_rdata  in  32  load data from the data memory
- resp_valid  out  1  one-cycle load completion pulse
- resp_tag  out  TAG_W  completed load's tag
- resp_data  out  32  completed load's data
- resp_pc  out  32  completed load's PC
- st_done  out  1  one-cycle store completion pulse
- busy  out  1  state is not IDLE
- err_timeout  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, LOOKUP, MEM_WAIT, RESP.
- IDLE is the only state in which ld_ready or st_ready can be 1. Exactly one of them is high, and only for the requester being granted.
- Grant rule:
  - Loads normally win.
  - A store wins when starve_cnt == STARVE_MAX.
  - A store also wins when a valid load's ld_addr equals st_addr, so the store is ordered before that load.
  - Only one requester valid: that requester wins.
- starve_cnt:
  - increments on a load grant while st_valid is high, saturating at STARVE_MAX
  - clears on a store grant or when st_valid is low
- Load accept: latch the request fields, drive cache_addr = latched address, go to LOOKUP.
- LOOKUP:
  - cache_hit=1: load resp_* from cache_data and go to RESP.
  - cache_hit=0: go to MEM_WAIT with mem_read_en=1 and mem_cache_miss=1.
  - For LB, resp_data = {24'b0, byte[7:0]} from whichever source supplied the data.
- Store accept: go straight to MEM_WAIT with mem_write_en=1.
- MEM_WAIT:
  - The enable and all mem_* fields stay stable until the done pulse.
  - A load completes on mem_data_valid: capture mem_rdata, go to RESP.
  - A store completes on mem_has_stored: pulse st_done, go to IDLE.
- Watchdog: a counter runs in MEM_WAIT. If no done pulse arrives within 2*MEM_LATENCY cycles, set err_timeout, drop the enables, and return to IDLE with no response.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Done pulses arriving outside MEM_WAIT are ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (ready, enables, resp_*, st_done, busy, err_timeout, mem_*, cache_addr); starve_cnt 0; watchdog 0.
- A reset asserted mid-operation aborts the operation with no response and no st_done.
- Load hit, accepted at edge T: LOOKUP during cycle T+1, resp_valid during T+2, next accept possible at T+3.
- Load miss: mem_read_en is high from cycle T+2 until the cycle mem_data_valid is seen (nominally MEM_LATENCY cycles). resp_valid follows in the next cycle.
- Store accepted at T: mem_write_en is high from T+1. st_done pulses in the same cycle mem_has_stored is sampled, and the block is in IDLE on the following cycle.
- Simultaneous ld_valid and st_valid are resolved in one cycle by the grant rule; there is never a double accept.
- Requester fields only need to be stable in the accept cycle.

## Structure
- Shared package holds:
  - optype constants LB=7, LW=8, SB=9, SW=10
  - the FSM state enum
  - the MEM_LATENCY default
- A natural sub-module is dmem_grant_arbiter: combinational grant logic plus the starve_cnt register.
- The FSM, latches and watchdog live in the top module.

## Test plan
- Load LW to address 0x10 with cache_hit=1 and cache_data=0xDEADBEEF → resp_valid 2 cycles after accept, resp_data 0xDEADBEEF, correct tag; mem_read_en never asserted.
- LB miss to address 0x20, memory model returning 0x123456AB after 10 cycles → mem_cache_miss=1; resp_data 0x000000AB one cycle after mem_data_valid.
- SW of 0xCAFEF00D to address 0x4 → mem_write_en held high until mem_has_stored; st_done pulses once; mem_data 0xCAFEF00D throughout.
- Loads and stores valid continuously to distinct addresses → after 4 load grants a store is granted; starve_cnt returns to 0.
- Load and store to the same address 0x30, valid in the same cycle → store granted first; the load returns the stored value from the memory model.
- Memory model withholds the done pulse → err_timeout set at 20 cycles, busy=0 next cycle; rst mid-MEM_WAIT → all outputs 0 on the next cycle, no resp_valid.
